// File: rtl/cache_pkg.sv
// Shared types for the cache request path: access kinds, request record, counter helper.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package cache_pkg;

    localparam int ADDR_W = 32;

    typedef enum logic [1:0] {
        READ       = 2'd0,
        WRITE      = 2'd1,
        INVALIDATE = 2'd2,
        ILLEGAL    = 2'd3
    } access_t;

    typedef struct packed {
        access_t             kind;
        logic [ADDR_W-1:0]   addr;
    } req_t;

    // Statistics counters stick at all-ones rather than wrapping back to zero.
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Generic single-clock FIFO with occupancy level; head data is read combinationally.
// Latency: an entry pushed at edge N is visible at the head from cycle N+1 (no bypass).
// Backpressure: pushes while full and pops while empty are ignored; caller gates with full/empty.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_dat,
    output logic [LVL_W-1:0] level,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == LVL_W'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign pop_dat = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two; level tracks push minus pop.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    // Storage needs no reset: stale contents are never presented while empty.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/cache_req_queue.sv
// Buffers trace accesses for the cache, drops illegal types, pre-decodes tag/index/offset, counts accepts.
// Latency: request accepted at edge N is presented to the cache in cycle N+1; 1 req/cycle sustained.
// Backpressure: in_ready drops only when the FIFO is full (independent of out_ready); head holds while out_ready low.
module cache_req_queue
    import cache_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int NUM_SETS  = 32,
    parameter int LINE_SIZE = 64,
    localparam int IDX_W = $clog2(NUM_SETS),
    localparam int OFF_W = $clog2(LINE_SIZE),
    localparam int TAG_W = ADDR_W - IDX_W - OFF_W,
    localparam int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_type,
    input  logic [ADDR_W-1:0] in_addr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [1:0]        out_type,
    output logic [ADDR_W-1:0] out_addr,
    output logic [TAG_W-1:0]  out_tag,
    output logic [IDX_W-1:0]  out_index,
    output logic [OFF_W-1:0]  out_offset,
    output logic [LVL_W-1:0]  level,
    output logic [15:0]       rd_count,
    output logic [15:0]       wr_count,
    output logic [15:0]       inv_count,
    output logic [15:0]       drop_count
);

    localparam int REQ_W = $bits(req_t);

    access_t          in_kind;
    logic             accept;
    logic             push;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;
    req_t             push_req;
    logic [REQ_W-1:0] head_dat;
    req_t             head;

    assign in_kind  = access_t'(in_type);
    assign in_ready = !fifo_full;
    assign accept   = in_valid && in_ready;
    // Illegal accesses are consumed upstream but never reach the cache.
    assign push     = accept && (in_kind != ILLEGAL);
    assign out_valid = !fifo_empty;
    assign pop      = out_valid && out_ready;

    assign push_req.kind = in_kind;
    assign push_req.addr = in_addr;

    sync_fifo #(
        .WIDTH (REQ_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_dat (push_req),
        .pop      (pop),
        .pop_dat  (head_dat),
        .level    (level),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // Head decode is purely combinational from stored state, so it is stable while stalled.
    always_comb begin
        head       = req_t'(head_dat);
        out_type   = head.kind;
        out_addr   = head.addr;
        out_tag    = head.addr[ADDR_W-1:IDX_W+OFF_W];
        out_index  = head.addr[IDX_W+OFF_W-1:OFF_W];
        out_offset = head.addr[OFF_W-1:0];
    end

    // Per-type accept counters, updated on the accepting edge, saturating at all-ones.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_count   <= '0;
            wr_count   <= '0;
            inv_count  <= '0;
            drop_count <= '0;
        end else if (accept) begin
            case (in_kind)
                READ:       rd_count   <= sat_inc(rd_count);
                WRITE:      wr_count   <= sat_inc(wr_count);
                INVALIDATE: inv_count  <= sat_inc(inv_count);
                default:    drop_count <= sat_inc(drop_count);
            endcase
        end
    end

endmodule

// File: doc/cache_req_queue.md
# cache_req_queue

Upstream request stage for the set-associative cache. Accepts trace accesses (read, write, invalidate plus a 32-bit address) over a valid/ready handshake and buffers them in a small FIFO. Pre-decodes each address into tag, index and offset for the configured geometry, then issues one request per cycle to the cache. Drops and counts illegal access types, and keeps per-type accept counters for cross-checking the cache's own statistics.

## Interface
- DEPTH, 4: FIFO entries; power of two, at least 2
- NUM_SETS, 32: cache sets; power of two; must match cache num_sets
- LINE_SIZE, 64: bytes per line; power of two; must match cache line_size
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-low reset
- in_valid  in  1  upstream request present
- in_ready  out  1  stage can accept
- in_type  in  2  0=read, 1=write, 2=invalidate, 3=illegal
- in_addr  in  32  byte address
- out_valid  out  1  request presented to cache
- out_ready  in  1  cache consumes the request
- out_type  out  2  access type of head entry
- out_addr  out  32  full address of head entry
- out_tag  out  32-IDX_W-OFF_W  address[31:IDX_W+OFF_W]
- out_index  out  IDX_W  address[IDX_W+OFF_W-1:OFF_W]
- out_offset  out  OFF_W  address[OFF_W-1:0]
- level  out  $clog2(DEPTH)+1  occupied entries
- rd_count, wr_count, inv_count, drop_count  out  16 each  saturating counters

## Operation
- IDX_W = $clog2(NUM_SETS), OFF_W = $clog2(LINE_SIZE). Defaults give 5, 6 and a 21-bit tag.
- Accept occurs when in_valid && in_ready.
- in_ready = (level != DEPTH). It has no dependence on out_ready, so there is no full-cycle pass-through.
- Accepted legal type (0–2): push {type, addr} and increment the matching counter.
- Accepted type 3: not pushed, drop_count increments, and in_ready behaves as for a legal access.
- Pop occurs when out_valid && out_ready. out_valid = (level != 0).
- Output fields come from the head entry, decoded combinationally from the stored address.
- While out_valid && !out_ready, all out_* fields hold stable.
- Simultaneous push and pop when not full and not empty: level is unchanged and both pointers advance.
- Empty FIFO: push only, no bypass.
- Pointers wrap modulo DEPTH.
- Counters saturate at 16'hFFFF and never wrap.

## Timing
- Reset (rst low at a clk edge): pointers, level and counters go to 0. This gives out_valid=0, in_ready=1, and all counters 0.
- out_* data fields are don't-care while out_valid=0.
- Reset mid-operation discards all entries at that edge; in_valid during reset is ignored.
- Latency: a request accepted at edge N gives out_valid=1 after edge N, i.e. it is presented in cycle N+1.
- Throughput: 1 request per cycle sustained when out_ready is held high.
- level and the counters update at the same edge as the accept or pop they reflect.

## Structure
- Package cache_pkg holds:
  - access_t enum: READ=0, WRITE=1, INVALIDATE=2, ILLEGAL=3
  - ADDR_W=32
  - req_t packed struct {access_t kind; logic [ADDR_W-1:0] addr;}
- cache_pkg is shared with the cache and the bench.
- Sub-module sync_fifo (parameters WIDTH, DEPTH) handles storage, pointers and level; it uses the same clk/rst convention.
- The top level holds the decode, drop filter and counters.

## Test plan
- Reset, then idle: out_valid=0, in_ready=1, level=0, all counters 0.
- Push {1, 0x12345678} with out_ready=0: next cycle out_valid=1, out_type=1, out_tag=0x2468A, out_index=0x19, out_offset=0x38, wr_count=1.
- Fill with out_ready=0: after 4 accepts, level=4 and in_ready=0. A 5th in_valid is not accepted and the counters are unchanged. Then out_ready=1 drains in order over 4 cycles.
- Back-to-back traffic with out_ready=1 and a stream of 0/1/2 types: one issue per cycle, level stays at 1, and rd/wr/inv counts match the stimulus.
- in_type=3 with address 0xDEADBEEF: accepted, drop_count=1, level unchanged, nothing issued.
- Reset asserted with level=3: the next cycle shows out_valid=0, level=0 and counters 0.
